sbox_issue_ctrl: RTL and testbench

- Issue controller for the shared masked (DOM) AES S-box pipeline: input linear map -> masked inversion stages -> output linear map.
- Arbitrates two byte requesters (A = round datapath, B = key schedule) onto the single S-box.
- Advances the S-box pipeline only when fresh randomness is valid.
- Tracks in-flight bytes so each result returns with its source and tag.

---
 rtl/sbox_ctrl_pkg.sv | 19 +
 rtl/sbox_track_sr.sv | 66 ++++++
 rtl/sbox_issue_ctrl.sv | 118 +++++++++++
 tb/tb_sbox_issue_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sbox_ctrl_pkg.sv
// Shared definitions for the masked S-box issue controller.
// Holds default geometry, requester source encoding and the issue FSM states.
// No ports; imported by sbox_track_sr and sbox_issue_ctrl.
package sbox_ctrl_pkg;

  localparam int PIPE_LAT_DEF = 5;
  localparam int SHARES_DEF   = 2;
  localparam int TAG_W_DEF    = 5;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } issue_state_t;

endpackage

// File: rtl/sbox_track_sr.sv
// In-flight tracker: PIPE_LAT entries of {valid, src, tag} that move in lock-step with the S-box.
// Ports: clk, clr (sync clear), en (shift), head_* (entry loaded at the input stage),
//        tail_* (entry leaving the output stage), busy (any valid), busy_nxt (any valid after this edge).
module sbox_track_sr
  import sbox_ctrl_pkg::*;
#(
  parameter int PIPE_LAT = PIPE_LAT_DEF,
  parameter int TAG_W    = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             head_vld,
  input  logic             head_src,
  input  logic [TAG_W-1:0] head_tag,
  output logic             tail_vld,
  output logic             tail_src,
  output logic [TAG_W-1:0] tail_tag,
  output logic             busy,
  output logic             busy_nxt
);

  logic [PIPE_LAT-1:0] vld;
  logic [PIPE_LAT-1:0] vld_nxt;
  logic [PIPE_LAT-1:0] src;
  logic [TAG_W-1:0]    tag [PIPE_LAT];

  // Next valid vector is exposed so the drain logic can see the pipeline
  // emptying in the same cycle the last byte retires.
  always_comb begin
    vld_nxt = vld;
    if (en) begin
      vld_nxt[0] = head_vld;
      for (int i = 1; i < PIPE_LAT; i++) begin
        vld_nxt[i] = vld[i-1];
      end
    end
    if (clr) begin
      vld_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    vld <= vld_nxt;
    if (clr) begin
      src <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        tag[i] <= '0;
      end
    end else if (en) begin
      src[0] <= head_src;
      tag[0] <= head_tag;
      for (int i = 1; i < PIPE_LAT; i++) begin
        src[i] <= src[i-1];
        tag[i] <= tag[i-1];
      end
    end
  end

  assign tail_vld = vld[PIPE_LAT-1];
  assign tail_src = src[PIPE_LAT-1];
  assign tail_tag = tag[PIPE_LAT-1];
  assign busy     = |vld;
  assign busy_nxt = |vld_nxt;

endmodule

// File: rtl/sbox_issue_ctrl.sv
// Issue controller for the shared masked S-box: round-robin A/B arbitration, randomness-gated
// pipeline advance, in-flight tracking and flush/drain sequencing.
// Ports: ClkxCI/RstxSI, requester A/B {Req, data, tag, Ack}, RandValidxSI, FlushxSI,
//        S-box {En, In, Out}, response {Valid, Src, Tag, data}, BusyxSO, FlushDonexSO.
module sbox_issue_ctrl
  import sbox_ctrl_pkg::*;
#(
  parameter int PIPE_LAT = PIPE_LAT_DEF,
  parameter int SHARES   = SHARES_DEF,
  parameter int TAG_W    = TAG_W_DEF
) (
  input  logic                  ClkxCI,
  input  logic                  RstxSI,
  input  logic                  ReqAxSI,
  input  logic [8*SHARES-1:0]   ReqAxDI,
  input  logic [TAG_W-1:0]      ReqATagxDI,
  output logic                  AckAxSO,
  input  logic                  ReqBxSI,
  input  logic [8*SHARES-1:0]   ReqBxDI,
  input  logic [TAG_W-1:0]      ReqBTagxDI,
  output logic                  AckBxSO,
  input  logic                  RandValidxSI,
  input  logic                  FlushxSI,
  output logic                  SboxEnxSO,
  output logic [8*SHARES-1:0]   SboxInxDO,
  input  logic [8*SHARES-1:0]   SboxOutxDI,
  output logic                  RspValidxSO,
  output logic                  RspSrcxSO,
  output logic [TAG_W-1:0]      RspTagxDO,
  output logic [8*SHARES-1:0]   RspxDO,
  output logic                  BusyxSO,
  output logic                  FlushDonexSO
);

  issue_state_t     state;
  logic             prio_b;     // 1: B wins a tie (A was granted last)
  logic             flush_done;
  logic             issue;
  logic             gnt_b;
  logic [TAG_W-1:0] head_tag;
  logic             tail_vld;
  logic             busy;
  logic             busy_nxt;

  // The whole pipeline, tracker included, moves only on fresh randomness.
  assign SboxEnxSO = RandValidxSI;

  // Issue is also suppressed during reset so no byte is acked and then discarded.
  assign gnt_b   = ReqBxSI & (~ReqAxSI | prio_b);
  assign issue   = (state == ST_RUN) & ~FlushxSI & RandValidxSI & ~RstxSI
                 & (ReqAxSI | ReqBxSI);
  assign AckAxSO = issue & ~gnt_b;
  assign AckBxSO = issue &  gnt_b;

  // Zero when idle so a stale share never sits on the S-box input.
  assign SboxInxDO = AckAxSO ? ReqAxDI : (AckBxSO ? ReqBxDI : '0);
  assign head_tag  = AckAxSO ? ReqATagxDI : (AckBxSO ? ReqBTagxDI : '0);

  sbox_track_sr #(
    .PIPE_LAT (PIPE_LAT),
    .TAG_W    (TAG_W)
  ) u_track (
    .clk      (ClkxCI),
    .clr      (RstxSI),
    .en       (RandValidxSI),
    .head_vld (issue),
    .head_src (gnt_b ? SRC_B : SRC_A),
    .head_tag (head_tag),
    .tail_vld (tail_vld),
    .tail_src (RspSrcxSO),
    .tail_tag (RspTagxDO),
    .busy     (busy),
    .busy_nxt (busy_nxt)
  );

  assign RspValidxSO  = tail_vld & RandValidxSI & ~RstxSI;
  assign RspxDO       = SboxOutxDI;
  assign BusyxSO      = busy;
  assign FlushDonexSO = flush_done;

  always_ff @(posedge ClkxCI) begin
    if (RstxSI) begin
      state      <= ST_RUN;
      prio_b     <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      if (issue) begin
        prio_b <= ~gnt_b;
      end
      case (state)
        ST_RUN: begin
          if (FlushxSI) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Leave as soon as the last in-flight byte retires this cycle.
          if (!busy_nxt) begin
            state      <= ST_DONE;
            flush_done <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= FlushxSI ? ST_DRAIN : ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  a_one_ack: assert property (@(posedge ClkxCI) !(AckAxSO && AckBxSO));

  a_req_a_hold: assert property (@(posedge ClkxCI) disable iff (RstxSI)
    (ReqAxSI && !AckAxSO) |=> (ReqAxSI && $stable(ReqAxDI) && $stable(ReqATagxDI)));

  a_req_b_hold: assert property (@(posedge ClkxCI) disable iff (RstxSI)
    (ReqBxSI && !AckBxSO) |=> (ReqBxSI && $stable(ReqBxDI) && $stable(ReqBTagxDI)));

endmodule

// File: tb/tb_sbox_issue_ctrl.sv
module tb_sbox_issue_ctrl;

  localparam int PL = 5;
  localparam int DW = 16;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          RstxSI = 1'b1;
  logic          ReqAxSI = 1'b0, ReqBxSI = 1'b0;
  logic [DW-1:0] ReqAxDI = '0, ReqBxDI = '0;
  logic [TW-1:0] ReqATagxDI = '0, ReqBTagxDI = '0;
  logic          AckAxSO, AckBxSO;
  logic          RandValidxSI = 1'b0, FlushxSI = 1'b0;
  logic          SboxEnxSO;
  logic [DW-1:0] SboxInxDO, SboxOutxDI = '0;
  logic          RspValidxSO, RspSrcxSO;
  logic [TW-1:0] RspTagxDO;
  logic [DW-1:0] RspxDO;
  logic          BusyxSO, FlushDonexSO;

  always #5 clk = ~clk;

  sbox_issue_ctrl dut (
    .ClkxCI(clk), .RstxSI(RstxSI),
    .ReqAxSI(ReqAxSI), .ReqAxDI(ReqAxDI), .ReqATagxDI(ReqATagxDI), .AckAxSO(AckAxSO),
    .ReqBxSI(ReqBxSI), .ReqBxDI(ReqBxDI), .ReqBTagxDI(ReqBTagxDI), .AckBxSO(AckBxSO),
    .RandValidxSI(RandValidxSI), .FlushxSI(FlushxSI),
    .SboxEnxSO(SboxEnxSO), .SboxInxDO(SboxInxDO), .SboxOutxDI(SboxOutxDI),
    .RspValidxSO(RspValidxSO), .RspSrcxSO(RspSrcxSO), .RspTagxDO(RspTagxDO), .RspxDO(RspxDO),
    .BusyxSO(BusyxSO), .FlushDonexSO(FlushDonexSO)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_on = 0;
  logic [TW-1:0] tag_a = '0, tag_b = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural model: ordered list of in-flight bytes, each counting the
  // enabled cycles it has spent inside the S-box.
  typedef struct { logic src; logic [TW-1:0] tag; int cnt; } fl_t;
  fl_t q[$];
  int  m_mode = 0;          // 0 run, 1 drain, 2 done
  bit  m_prio_b = 0;

  typedef struct { int cyc; logic src; logic [TW-1:0] tag; logic [DW-1:0] dat; } ev_t;
  ev_t ack_log[$];
  ev_t rsp_log[$];
  int  fd_log[$];

  always @(negedge clk) begin
    logic e_en, e_ret, e_iss, e_gb;
    logic [DW-1:0] e_in;
    e_en  = RandValidxSI;
    e_ret = !RstxSI && e_en && (q.size() > 0) && (q[0].cnt == PL);
    e_iss = !RstxSI && (m_mode == 0) && !FlushxSI && e_en && (ReqAxSI || ReqBxSI);
    e_gb  = ReqBxSI && (!ReqAxSI || m_prio_b);
    e_in  = e_iss ? (e_gb ? ReqBxDI : ReqAxDI) : '0;
    if (chk_on) begin
      chk("sbox_en", SboxEnxSO, e_en);
      chk("ack_a", AckAxSO, e_iss && !e_gb);
      chk("ack_b", AckBxSO, e_iss && e_gb);
      chk("sbox_in", SboxInxDO, e_in);
      chk("rsp_valid", RspValidxSO, e_ret);
      if (e_ret) begin
        chk("rsp_src", RspSrcxSO, q[0].src);
        chk("rsp_tag", RspTagxDO, q[0].tag);
      end
      chk("rsp_dat", RspxDO, SboxOutxDI);
      chk("busy", BusyxSO, q.size() != 0);
      chk("flush_done", FlushDonexSO, m_mode == 2);
      if (AckAxSO || AckBxSO)
        ack_log.push_back('{cyc: cyc, src: AckBxSO, tag: AckBxSO ? ReqBTagxDI : ReqATagxDI, dat: SboxInxDO});
      if (RspValidxSO)
        rsp_log.push_back('{cyc: cyc, src: RspSrcxSO, tag: RspTagxDO, dat: RspxDO});
      if (FlushDonexSO) fd_log.push_back(cyc);
    end
    if (RstxSI) begin
      q.delete();
      m_mode = 0;
      m_prio_b = 0;
    end else begin
      if (e_en) begin
        if (e_ret) void'(q.pop_front());
        foreach (q[i]) q[i].cnt = q[i].cnt + 1;
        if (e_iss) q.push_back('{src: e_gb, tag: e_gb ? ReqBTagxDI : ReqATagxDI, cnt: 1});
      end
      if (e_iss) m_prio_b = !e_gb;
      case (m_mode)
        0: if (FlushxSI) m_mode = 1;
        1: if (q.size() == 0) m_mode = 2;
        default: m_mode = FlushxSI ? 1 : 0;
      endcase
    end
  end

  function automatic ev_t ack_at(int i);
    ev_t d = '{cyc: -100, src: 1'bx, tag: 'x, dat: 'x};
    return (i < ack_log.size()) ? ack_log[i] : d;
  endfunction

  function automatic ev_t rsp_at(int i);
    ev_t d = '{cyc: -100, src: 1'bx, tag: 'x, dat: 'x};
    return (i < rsp_log.size()) ? rsp_log[i] : d;
  endfunction

  function automatic int fd_at(int i);
    return (i < fd_log.size()) ? fd_log[i] : -100;
  endfunction

  // One cycle: (re)assert requests, drive controls, hold until the edge,
  // then drop any request that was acked.
  task automatic step(input bit wa, input bit wb, input bit rnd, input bit fl, input bit rs);
    logic ga, gb;
    if (wa && !ReqAxSI) begin ReqAxSI = 1; ReqATagxDI = tag_a; ReqAxDI = DW'($urandom); tag_a++; end
    if (wb && !ReqBxSI) begin ReqBxSI = 1; ReqBTagxDI = tag_b; ReqBxDI = DW'($urandom); tag_b++; end
    RandValidxSI = rnd;
    FlushxSI = fl;
    RstxSI = rs;
    SboxOutxDI = DW'($urandom);
    #1;
    ga = AckAxSO;
    gb = AckBxSO;
    @(posedge clk);
    #1;
    if (ga) ReqAxSI = 0;
    if (gb) ReqBxSI = 0;
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    ack_log.delete();
    rsp_log.delete();
    fd_log.delete();
  endtask

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_ack_a"}, AckAxSO, 0);
    chk({pfx, "_ack_b"}, AckBxSO, 0);
    chk({pfx, "_sbox_en"}, SboxEnxSO, 0);
    chk({pfx, "_sbox_in"}, SboxInxDO, 0);
    chk({pfx, "_rsp_valid"}, RspValidxSO, 0);
    chk({pfx, "_rsp_src"}, RspSrcxSO, 0);
    chk({pfx, "_rsp_tag"}, RspTagxDO, 0);
    chk({pfx, "_busy"}, BusyxSO, 0);
    chk({pfx, "_flush_done"}, FlushDonexSO, 0);
  endtask

  initial begin
    int c, f;
    // Reset state
    do_reset();
    check_all_zero("reset");
    chk_on = 1;

    // T1: single A byte, tag 0x03, shares 0xA5/0x3C
    ReqAxSI = 1; ReqAxDI = 16'hA53C; ReqATagxDI = 5'h03;
    step(1, 0, 1, 0, 0);
    repeat (8) step(0, 0, 1, 0, 0);
    chk("t1_ack_count", ack_log.size(), 1);
    chk("t1_ack_src", ack_at(0).src, 0);
    chk("t1_sbox_in", ack_at(0).dat, 16'hA53C);
    chk("t1_rsp_count", rsp_log.size(), 1);
    chk("t1_latency", rsp_at(0).cyc - ack_at(0).cyc, 5);
    chk("t1_rsp_src", rsp_at(0).src, 0);
    chk("t1_rsp_tag", rsp_at(0).tag, 5'h03);

    // T2: A and B both requesting for 8 cycles
    do_reset();
    tag_a = 5'h10; tag_b = 5'h18;
    repeat (8) step(1, 1, 1, 0, 0);
    repeat (10) step(0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_ack_src%0d", i), ack_at(i).src, i % 2);
      chk($sformatf("t2_ack_cyc%0d", i), ack_at(i).cyc - ack_at(0).cyc, i);
      chk($sformatf("t2_rsp_src%0d", i), rsp_at(i).src, i % 2);
      chk($sformatf("t2_rsp_tag%0d", i), rsp_at(i).tag, (i % 2) ? 5'h18 + i / 2 : 5'h10 + i / 2);
      chk($sformatf("t2_rsp_cyc%0d", i), rsp_at(i).cyc - ack_at(0).cyc, 5 + i);
    end

    // T3: randomness low for 3 cycles after issue, B waiting meanwhile
    do_reset();
    tag_a = 5'h01; tag_b = 5'h07;
    step(1, 0, 1, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0);
    repeat (10) step(0, 0, 1, 0, 0);
    chk("t3_stall_latency", rsp_at(0).cyc - ack_at(0).cyc, 8);
    chk("t3_b_src", ack_at(1).src, 1);
    chk("t3_b_after_stall", ack_at(1).cyc - ack_at(0).cyc, 4);
    chk("t3_b_latency", rsp_at(1).cyc - ack_at(1).cyc, 5);
    chk("t3_b_tag", rsp_at(1).tag, 5'h07);

    // T4: 4 in flight, flush with A pending
    do_reset();
    tag_a = 5'h00;
    repeat (4) step(1, 0, 1, 0, 0);
    step(1, 0, 1, 1, 0);
    repeat (10) step(0, 0, 1, 0, 0);
    c = ack_at(0).cyc;
    chk("t4_ack_count", ack_log.size(), 5);
    chk("t4_last_rsp", rsp_at(3).cyc - c, 8);
    chk("t4_fd_count", fd_log.size(), 1);
    chk("t4_fd_after_rsp", fd_at(0) - rsp_at(3).cyc, 1);
    chk("t4_ack_after_fd", ack_at(4).cyc - fd_at(0), 1);
    chk("t4_pending_tag", ack_at(4).tag, 5'h04);
    // Flush with an empty pipeline
    f = cyc;
    step(0, 0, 1, 1, 0);
    repeat (4) step(0, 0, 1, 0, 0);
    chk("t4_empty_fd_count", fd_log.size(), 2);
    chk("t4_empty_fd_cyc", fd_at(1) - f, 2);

    // T5: reset with 3 bytes in flight
    do_reset();
    repeat (3) step(1, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    RandValidxSI = 0;
    #1;
    check_all_zero("t5");
    repeat (8) step(0, 0, 1, 0, 0);
    chk("t5_no_rsp", rsp_log.size(), 0);
    chk("t5_no_fd", fd_log.size(), 0);

    // T6: B alone for 6 cycles, then A and B together
    do_reset();
    tag_a = 5'h0A; tag_b = 5'h00;
    repeat (6) step(0, 1, 1, 0, 0);
    repeat (2) step(1, 1, 1, 0, 0);
    repeat (10) step(0, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) chk($sformatf("t6_b_only%0d", i), ack_at(i).src, 1);
    chk("t6_b_back_to_back", ack_at(5).cyc - ack_at(0).cyc, 5);
    chk("t6_a_first", ack_at(6).src, 0);
    chk("t6_a_tag", ack_at(6).tag, 5'h0A);
    chk("t6_then_b", ack_at(7).src, 1);
    chk("t6_no_bubble", ack_at(6).cyc - ack_at(5).cyc, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
